// File: rtl/cordic_input_standardizer_pipe.sv
// CORDIC front end: folds each (x, y) sample into the first quadrant with a q*90deg
// clockwise pre-rotation, reports q, and registers the result behind a valid/ready stage.
module cordic_input_standardizer_pipe #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 15,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [DATA_W-1:0]  x_in,
  input  logic [DATA_W-1:0]  y_in,
  input  logic [ANGLE_W:0]   theta_in,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  x_out,
  output logic [DATA_W-1:0]  y_out,
  output logic [ANGLE_W-3:0] theta_out,
  output logic [1:0]         quadrant,
  output logic               mode_out,
  output logic [TAG_W-1:0]   tag_out,
  output logic               sat_out
);

  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic [ANGLE_W-1:0] angle;
  logic               x_neg;
  logic               y_neg;
  logic               x_min;
  logic               y_min;
  logic [DATA_W-1:0]  x_ngt;
  logic [DATA_W-1:0]  y_ngt;
  logic [1:0]         q_nxt;
  logic [DATA_W-1:0]  x_nxt;
  logic [DATA_W-1:0]  y_nxt;
  logic [ANGLE_W-3:0] theta_nxt;
  logic               sat_nxt;
  logic               accept;

  // Handshake: a beat moves when valid && ready on either side. The single output
  // register may reload in the same cycle it is drained, so in_ready looks through
  // to out_ready and the stage sustains one beat per cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The MSB of theta_in only matters as a wrap bit, so a full turn folds to 0.
  assign angle = theta_in[ANGLE_W-1:0];

  assign x_neg = x_in[DATA_W-1];
  assign y_neg = y_in[DATA_W-1];
  assign x_min = (x_in == S_MIN);
  assign y_min = (y_in == S_MIN);
  assign x_ngt = x_min ? S_MAX : -x_in;
  assign y_ngt = y_min ? S_MAX : -y_in;

  always_comb begin
    q_nxt     = 2'd0;
    x_nxt     = x_in;
    y_nxt     = y_in;
    theta_nxt = '0;
    sat_nxt   = 1'b0;
    if (in_mode) begin
      // Sign-derived quadrant: upper bit is y<0, lower bit distinguishes q1/q3.
      q_nxt = {y_neg, x_neg ^ y_neg};
    end else begin
      q_nxt     = angle[ANGLE_W-1:ANGLE_W-2];
      theta_nxt = angle[ANGLE_W-3:0];
    end
    case (q_nxt)
      2'd0: begin
        x_nxt = x_in;
        y_nxt = y_in;
      end
      2'd1: begin
        x_nxt   = y_in;
        y_nxt   = x_ngt;
        sat_nxt = x_min;
      end
      2'd2: begin
        x_nxt   = x_ngt;
        y_nxt   = y_ngt;
        sat_nxt = x_min || y_min;
      end
      default: begin
        x_nxt   = y_ngt;
        y_nxt   = x_in;
        sat_nxt = y_min;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      theta_out <= '0;
      quadrant  <= '0;
      mode_out  <= 1'b0;
      tag_out   <= '0;
      sat_out   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      x_out     <= x_nxt;
      y_out     <= y_nxt;
      theta_out <= theta_nxt;
      quadrant  <= q_nxt;
      mode_out  <= in_mode;
      tag_out   <= tag_in;
      sat_out   <= sat_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cordic_input_standardizer_pipe.sv
// Bench for cordic_input_standardizer_pipe: directed vector table, stream/stall and
// reset sequences, and randomized beats scored against an arithmetic reference model.
module tb_cordic_input_standardizer_pipe;

  localparam int DW    = 16;
  localparam int AW    = 15;
  localparam int TW    = 4;
  localparam int EXP_W = 2*DW + (AW-2) + 2 + 1 + TW + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] x_in;
  logic [DW-1:0] y_in;
  logic [AW:0]   theta_in;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] x_out;
  logic [DW-1:0] y_out;
  logic [AW-3:0] theta_out;
  logic [1:0]    quadrant;
  logic          mode_out;
  logic [TW-1:0] tag_out;
  logic          sat_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  cordic_input_standardizer_pipe #(.DATA_W(DW), .ANGLE_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .theta_in(theta_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .theta_out(theta_out), .quadrant(quadrant),
    .mode_out(mode_out), .tag_out(tag_out), .sat_out(sat_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [EXP_W-1:0] actual();
    return {x_out, y_out, theta_out, quadrant, mode_out, tag_out, sat_out};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: rotate by whole quarter turns in unbounded integers, then clamp.
  function automatic logic [EXP_W-1:0] model(input logic mode, input logic [DW-1:0] x,
                                             input logic [DW-1:0] y, input logic [AW:0] theta,
                                             input logic [TW-1:0] tag);
    int xs, ys, xr, yr, q, a, res, maxv;
    logic sat;
    logic [DW-1:0] xo, yo;
    logic [AW-3:0] to;
    logic [1:0] qo;
    xs = $signed(x);
    ys = $signed(y);
    a = int'(theta) % (1 << AW);
    if (!mode) begin
      q   = a / (1 << (AW-2));
      res = a % (1 << (AW-2));
    end else begin
      res = 0;
      if (xs >= 0 && ys >= 0) q = 0;
      else if (xs < 0 && ys >= 0) q = 1;
      else if (xs < 0) q = 2;
      else q = 3;
    end
    case (q)
      0: begin xr = xs;  yr = ys;  end
      1: begin xr = ys;  yr = -xs; end
      2: begin xr = -xs; yr = -ys; end
      default: begin xr = -ys; yr = xs; end
    endcase
    maxv = (1 << (DW-1)) - 1;
    sat = 1'b0;
    if (xr > maxv) begin xr = maxv; sat = 1'b1; end
    if (yr > maxv) begin yr = maxv; sat = 1'b1; end
    xo = xr[DW-1:0];
    yo = yr[DW-1:0];
    to = res[AW-3:0];
    qo = q[1:0];
    return {xo, yo, to, qo, mode, tag, sat};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [EXP_W-1:0] held;
  logic             hold_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(actual()), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", actual(), $time);
        end else begin
          check("scoreboard", 64'(actual()), 64'(exp_q.pop_front()));
        end
      end
      hold_v = out_valid && !out_ready;
      held   = actual();
      if (in_valid && in_ready)
        exp_q.push_back(model(in_mode, x_in, y_in, theta_in, tag_in));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic mode, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [AW:0] theta, input logic [TW-1:0] tag);
    logic acc;
    in_valid = 1'b1;
    in_mode  = mode;
    x_in     = x;
    y_in     = y;
    theta_in = theta;
    tag_in   = tag;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles at %0t", $time);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
  endtask

  function automatic logic [DW-1:0] rand_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 5))
      0: v = {1'b1, {(DW-1){1'b0}}};
      1: v = {1'b0, {(DW-1){1'b1}}};
      2: v = '0;
      3: v = '1;
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          mode;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [AW:0]   theta;
    logic [TW-1:0] tag;
    logic [DW-1:0] ex;
    logic [DW-1:0] ey;
    logic [AW-3:0] et;
    logic [1:0]    eq;
    logic          es;
  } vec_t;

  vec_t vecs[10];
  logic stream_done;

  initial begin
    vecs[0] = '{1'b0, 16'h4000, 16'h0000, 16'h2100, 4'h1, 16'h0000, 16'hC000, 13'd256,  2'd1, 1'b0};
    vecs[1] = '{1'b0, 16'h1234, 16'h0567, 16'h8000, 4'h2, 16'h1234, 16'h0567, 13'd0,    2'd0, 1'b0};
    vecs[2] = '{1'b0, 16'h8000, 16'h8000, 16'h4000, 4'h3, 16'h7FFF, 16'h7FFF, 13'd0,    2'd2, 1'b1};
    vecs[3] = '{1'b1, 16'hFF9C, 16'hFF38, 16'h1234, 4'h4, 16'h0064, 16'h00C8, 13'd0,    2'd2, 1'b0};
    vecs[4] = '{1'b1, 16'h0032, 16'hFFF9, 16'h0000, 4'h5, 16'h0007, 16'h0032, 13'd0,    2'd3, 1'b0};
    vecs[5] = '{1'b0, 16'h8000, 16'h0005, 16'h7000, 4'h6, 16'hFFFB, 16'h8000, 13'd4096, 2'd3, 1'b0};
    vecs[6] = '{1'b0, 16'h0001, 16'h0002, 16'hFFFF, 4'h7, 16'hFFFE, 16'h0001, 13'h1FFF, 2'd3, 1'b0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 16'h5555, 4'h8, 16'h0000, 16'h0000, 13'd0,    2'd0, 1'b0};
    vecs[8] = '{1'b1, 16'h8000, 16'h0000, 16'h0000, 4'h9, 16'h0000, 16'h7FFF, 13'd0,    2'd1, 1'b1};
    vecs[9] = '{1'b1, 16'h8000, 16'h8000, 16'h0000, 4'hA, 16'h7FFF, 16'h7FFF, 13'd0,    2'd2, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    x_in = '0;
    y_in = '0;
    theta_in = '0;
    tag_in = '0;
    out_ready = 1'b1;
    stream_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_data", 64'(actual()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table: one beat each, checked one cycle after accept.
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      send_beat(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].theta, vecs[i].tag);
      in_valid = 1'b0;
      check("vec_valid", 64'(out_valid), 64'd1);
      check("vec_x", 64'(x_out), 64'(vecs[i].ex));
      check("vec_y", 64'(y_out), 64'(vecs[i].ey));
      check("vec_theta", 64'(theta_out), 64'(vecs[i].et));
      check("vec_q", 64'(quadrant), 64'(vecs[i].eq));
      check("vec_sat", 64'(sat_out), 64'(vecs[i].es));
      check("vec_tag_mode", 64'({tag_out, mode_out}), 64'({vecs[i].tag, vecs[i].mode}));
    end
    drain();

    // Back-to-back stream of 8 beats with out_ready toggling 1010...
    out_ready = 1'b1;
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_beat(1'b0, DW'($urandom), DW'($urandom), (AW+1)'($urandom), TW'(i));
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    drain();

    // Randomized beats with random gaps and random backpressure.
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send_beat(1'($urandom), rand_val(), rand_val(), (AW+1)'($urandom), TW'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Reset while holding a stalled beat, then accept in the first post-reset cycle.
    out_ready = 1'b0;
    send_beat(1'b0, 16'h0100, 16'h0200, 16'h2000, 4'hC);
    in_valid = 1'b0;
    check("t6_full", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_data", 64'(actual()), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_mode = 1'b1;
    x_in = 16'hFFFF;
    y_in = 16'h0003;
    theta_in = '0;
    tag_in = 4'hD;
    @(negedge clk);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t6_post_valid", 64'(out_valid), 64'd1);
    check("t6_post_beat", 64'({x_out, y_out, quadrant, tag_out, sat_out}),
          64'({16'h0003, 16'h0001, 2'd1, 4'hD, 1'b0}));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
